// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// Arbitrates the single register-file write port between the in-order
// pipeline writeback and a long-latency unit (LU). Pipeline writes always win.
// LU results that cannot be written immediately are parked in a small FIFO,
// which drains whenever the pipeline leaves the port idle. A 32-entry busy
// scoreboard tracks destinations of outstanding LU ops so that decode can be
// stalled on RAW/WAW hazards. A starvation counter asks the pipeline for a
// writeback bubble when the FIFO has been stuck behind pipe writes for too
// long. Protocol violations raise a sticky error flag but never block
// the operation.
//
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   pipe_wren_i/rd_addr_i/rd_data_i pipeline writeback request (never stalled)
//   lu_valid_i/rd_addr_i/rd_data_i LU result offer
//   lu_ready_o                     FIFO has room (registered state only)
//   issue_i, issue_rd_addr_i       LU op issued, destination becomes busy
//   dec_rs1/rs2/rd_addr_i          decode-stage operands for hazard check
//   stall_o                        decode must hold
//   pipe_hold_o                    pipeline should insert one writeback bubble
//   rd_wren_o/rd_addr_o/rd_data_o  register-file write port (combinational)
//   err_o                          sticky protocol error
module regfile_wb_sched #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pipe_wren_i,
  input  logic [4:0]  pipe_rd_addr_i,
  input  logic [31:0] pipe_rd_data_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_rd_addr_i,
  input  logic [31:0] lu_rd_data_i,
  output logic        lu_ready_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_rd_addr_i,
  input  logic [4:0]  dec_rs1_addr_i,
  input  logic [4:0]  dec_rs2_addr_i,
  input  logic [4:0]  dec_rd_addr_i,
  output logic        stall_o,
  output logic        pipe_hold_o,
  output logic        rd_wren_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      busy;
  logic [SC_W-1:0]  starve_cnt;
  logic             err_q;

  logic [4:0]       buf_addr [DEPTH];
  logic [31:0]      buf_data [DEPTH];

  logic             sel_vld;
  logic             head_sel;
  logic             bypass;
  logic [4:0]       sel_addr;
  logic [31:0]      sel_data;
  logic             lu_fire;
  logic             enq;
  logic             err_evt;
  logic [31:0]      busy_nxt;

  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
    if (v >= SC_W'(STARVE_MAX)) return SC_W'(STARVE_MAX);
    else                        return v + SC_W'(1);
  endfunction

  // Write-port selection: pipe > FIFO head > direct LU bypass.
  always_comb begin
    sel_vld  = 1'b0;
    head_sel = 1'b0;
    bypass   = 1'b0;
    sel_addr = pipe_rd_addr_i;
    sel_data = pipe_rd_data_i;
    if (pipe_wren_i) begin
      sel_vld = 1'b1;
    end else if (count != '0) begin
      sel_vld  = 1'b1;
      head_sel = 1'b1;
      sel_addr = buf_addr[rd_ptr];
      sel_data = buf_data[rd_ptr];
    end else if (lu_valid_i) begin
      sel_vld  = 1'b1;
      bypass   = 1'b1;
      sel_addr = lu_rd_addr_i;
      sel_data = lu_rd_data_i;
    end
  end

  // x0 writes still consume their slot but never reach the register file;
  // nothing is written while reset is held.
  assign rd_wren_o = sel_vld & (sel_addr != 5'd0) & ~rst_i;
  assign rd_addr_o = sel_addr;
  assign rd_data_o = sel_data;

  assign lu_ready_o  = (count < CNT_W'(DEPTH));
  assign lu_fire     = lu_valid_i & lu_ready_o;
  assign enq         = lu_fire & ~bypass;
  assign stall_o     = busy[dec_rs1_addr_i] | busy[dec_rs2_addr_i] | busy[dec_rd_addr_i];
  assign pipe_hold_o = (starve_cnt == SC_W'(STARVE_MAX));
  assign err_o       = err_q;

  assign err_evt = (pipe_wren_i & busy[pipe_rd_addr_i])
                 | (issue_i & busy[issue_rd_addr_i])
                 | (lu_fire & (lu_rd_addr_i != 5'd0) & ~busy[lu_rd_addr_i]);

  // Clear from an LU write first, then the issue set, so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (head_sel | bypass) busy_nxt[sel_addr] = 1'b0;
    if (issue_i)           busy_nxt[issue_rd_addr_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Control state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      busy       <= '0;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      if (enq)      wr_ptr <= wr_ptr + PTR_W'(1);
      if (head_sel) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, head_sel})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      busy <= busy_nxt;
      if (pipe_wren_i && (count != '0)) starve_cnt <= sat_inc(starve_cnt);
      else                              starve_cnt <= '0;
      if (err_evt) err_q <= 1'b1;
    end
  end

  // FIFO storage (data only, not reset)
  always_ff @(posedge clk_i) begin
    if (enq) begin
      buf_addr[wr_ptr] <= lu_rd_addr_i;
      buf_data[wr_ptr] <= lu_rd_data_i;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        pipe_wren_i;
  logic [4:0]  pipe_rd_addr_i;
  logic [31:0] pipe_rd_data_i;
  logic        lu_valid_i;
  logic [4:0]  lu_rd_addr_i;
  logic [31:0] lu_rd_data_i;
  logic        lu_ready_o;
  logic        issue_i;
  logic [4:0]  issue_rd_addr_i;
  logic [4:0]  dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i;
  logic        stall_o, pipe_hold_o, rd_wren_o, err_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_sched #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .pipe_wren_i(pipe_wren_i), .pipe_rd_addr_i(pipe_rd_addr_i), .pipe_rd_data_i(pipe_rd_data_i),
    .lu_valid_i(lu_valid_i), .lu_rd_addr_i(lu_rd_addr_i), .lu_rd_data_i(lu_rd_data_i),
    .lu_ready_o(lu_ready_o),
    .issue_i(issue_i), .issue_rd_addr_i(issue_rd_addr_i),
    .dec_rs1_addr_i(dec_rs1_addr_i), .dec_rs2_addr_i(dec_rs2_addr_i), .dec_rd_addr_i(dec_rd_addr_i),
    .stall_o(stall_o), .pipe_hold_o(pipe_hold_o),
    .rd_wren_o(rd_wren_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .err_o(err_o)
  );

  task automatic idle_inputs();
    pipe_wren_i = 0; pipe_rd_addr_i = 0; pipe_rd_data_i = 0;
    lu_valid_i = 0; lu_rd_addr_i = 0; lu_rd_data_i = 0;
    issue_i = 0; issue_rd_addr_i = 0;
    dec_rs1_addr_i = 0; dec_rs2_addr_i = 0; dec_rd_addr_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    tick();
    tick();
    rst_i = 0;
    #1;
  endtask

  task automatic pipe_set(input logic en, input logic [4:0] a, input logic [31:0] d);
    pipe_wren_i = en; pipe_rd_addr_i = a; pipe_rd_data_i = d;
  endtask

  task automatic lu_set(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid_i = v; lu_rd_addr_i = a; lu_rd_data_i = d;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_i = 1; issue_rd_addr_i = a;
    tick();
    issue_i = 0; issue_rd_addr_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1;
    pipe_set(1, 5'd3, 32'hABCD);
    dec_rs1_addr_i = 5'd3;
    tick();
    checks++; if (lu_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", lu_ready_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
    checks++; if (pipe_hold_o !== 1'b0) begin failures++; $display("FAIL rst_hold got=%b exp=0", pipe_hold_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_o); end
    checks++; if (rd_wren_o !== 1'b0) begin failures++; $display("FAIL rst_wren got=%b exp=0", rd_wren_o); end
    rst_i = 0;
    #1;
    checks++; if (rd_wren_o !== 1'b1) begin failures++; $display("FAIL rst_rel_wren got=%b exp=1", rd_wren_o); end
    checks++; if (rd_addr_o !== 5'd3) begin failures++; $display("FAIL rst_rel_addr got=%0d exp=3", rd_addr_o); end
    idle_inputs();
  endtask

  task automatic test_bypass();
    do_reset();
    issue(5'd5);
    dec_rs1_addr_i = 5'd5;
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL byp_stall_set got=%b exp=1", stall_o); end
    lu_set(1, 5'd5, 32'h1234);
    #1;
    checks++; if (rd_wren_o !== 1'b1) begin failures++; $display("FAIL byp_wren got=%b exp=1", rd_wren_o); end
    checks++; if (rd_addr_o !== 5'd5) begin failures++; $display("FAIL byp_addr got=%0d exp=5", rd_addr_o); end
    checks++; if (rd_data_o !== 32'h1234) begin failures++; $display("FAIL byp_data got=%h exp=1234", rd_data_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL byp_stall_same got=%b exp=1", stall_o); end
    tick();
    lu_set(0, 0, 0);
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL byp_stall_clr got=%b exp=0", stall_o); end
    checks++; if (rd_wren_o !== 1'b0) begin failures++; $display("FAIL byp_not_enq got=%b exp=0", rd_wren_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL byp_err got=%b exp=0", err_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    issue(5'd6); issue(5'd7); issue(5'd8);
    pipe_set(1, 5'd10, 32'hA0); lu_set(1, 5'd6, 32'h66);
    #1;
    checks++; if (lu_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%b exp=1", lu_ready_o); end
    checks++; if (rd_addr_o !== 5'd10) begin failures++; $display("FAIL bp_pipe_addr got=%0d exp=10", rd_addr_o); end
    tick();
    pipe_set(1, 5'd11, 32'hA1); lu_set(1, 5'd7, 32'h77);
    #1;
    checks++; if (lu_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", lu_ready_o); end
    tick();
    pipe_set(1, 5'd12, 32'hA2); lu_set(1, 5'd8, 32'h88);
    #1;
    checks++; if (lu_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", lu_ready_o); end
    tick();
    pipe_set(1, 5'd13, 32'hA3);
    #1;
    checks++; if (pipe_hold_o !== 1'b0) begin failures++; $display("FAIL bp_hold got=%b exp=0", pipe_hold_o); end
    tick();
    pipe_set(0, 0, 0);
    #1;
    checks++; if (rd_wren_o !== 1'b1) begin failures++; $display("FAIL bp_drain0_wren got=%b exp=1", rd_wren_o); end
    checks++; if (rd_addr_o !== 5'd6) begin failures++; $display("FAIL bp_drain0_addr got=%0d exp=6", rd_addr_o); end
    checks++; if (rd_data_o !== 32'h66) begin failures++; $display("FAIL bp_drain0_data got=%h exp=66", rd_data_o); end
    checks++; if (lu_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_still_full got=%b exp=0", lu_ready_o); end
    tick();
    #1;
    checks++; if (rd_addr_o !== 5'd7) begin failures++; $display("FAIL bp_drain1_addr got=%0d exp=7", rd_addr_o); end
    checks++; if (rd_data_o !== 32'h77) begin failures++; $display("FAIL bp_drain1_data got=%h exp=77", rd_data_o); end
    checks++; if (lu_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_room got=%b exp=1", lu_ready_o); end
    tick();
    lu_set(0, 0, 0);
    #1;
    checks++; if (rd_addr_o !== 5'd8) begin failures++; $display("FAIL bp_drain2_addr got=%0d exp=8", rd_addr_o); end
    checks++; if (rd_data_o !== 32'h88) begin failures++; $display("FAIL bp_drain2_data got=%h exp=88", rd_data_o); end
    tick();
    dec_rs1_addr_i = 5'd6; dec_rs2_addr_i = 5'd7; dec_rd_addr_i = 5'd8;
    #1;
    checks++; if (rd_wren_o !== 1'b0) begin failures++; $display("FAIL bp_empty_wren got=%b exp=0", rd_wren_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL bp_stall got=%b exp=0", stall_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL bp_err got=%b exp=0", err_o); end
    idle_inputs();
  endtask

  task automatic test_starvation();
    do_reset();
    issue(5'd6);
    pipe_set(1, 5'd10, 32'h10); lu_set(1, 5'd6, 32'h600);
    tick();
    lu_set(0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      pipe_set(1, 5'(10 + i), 32'(i));
      #1;
      checks++; if (pipe_hold_o !== 1'b0) begin failures++; $display("FAIL st_hold_early cyc=%0d got=%b exp=0", i, pipe_hold_o); end
      tick();
    end
    pipe_set(1, 5'd15, 32'h5);
    #1;
    checks++; if (pipe_hold_o !== 1'b1) begin failures++; $display("FAIL st_hold_5th got=%b exp=1", pipe_hold_o); end
    tick();
    pipe_set(0, 0, 0);
    #1;
    checks++; if (pipe_hold_o !== 1'b1) begin failures++; $display("FAIL st_hold_drain got=%b exp=1", pipe_hold_o); end
    checks++; if (rd_addr_o !== 5'd6 || rd_wren_o !== 1'b1) begin failures++; $display("FAIL st_drain got=%0d/%b exp=6/1", rd_addr_o, rd_wren_o); end
    tick();
    #1;
    checks++; if (pipe_hold_o !== 1'b0) begin failures++; $display("FAIL st_hold_clr got=%b exp=0", pipe_hold_o); end
    idle_inputs();
  endtask

  task automatic test_x0();
    do_reset();
    issue(5'd0);
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL x0_busy got=%b exp=0", stall_o); end
    lu_set(1, 5'd0, 32'hFFFF);
    #1;
    checks++; if (rd_wren_o !== 1'b0) begin failures++; $display("FAIL x0_wren got=%b exp=0", rd_wren_o); end
    checks++; if (lu_ready_o !== 1'b1) begin failures++; $display("FAIL x0_ready got=%b exp=1", lu_ready_o); end
    tick();
    lu_set(0, 0, 0);
    #1;
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL x0_err got=%b exp=0", err_o); end
    checks++; if (lu_ready_o !== 1'b1 || rd_wren_o !== 1'b0) begin failures++; $display("FAIL x0_after got=%b/%b exp=1/0", lu_ready_o, rd_wren_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(5'd6); issue(5'd7);
    pipe_set(1, 5'd10, 32'h1); lu_set(1, 5'd6, 32'h66);
    tick();
    pipe_set(1, 5'd11, 32'h2); lu_set(1, 5'd7, 32'h77);
    tick();
    lu_set(0, 0, 0);
    dec_rs1_addr_i = 5'd6; dec_rs2_addr_i = 5'd7;
    #1;
    checks++; if (lu_ready_o !== 1'b0) begin failures++; $display("FAIL rm_full got=%b exp=0", lu_ready_o); end
    rst_i = 1;
    #1;
    checks++; if (lu_ready_o !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", lu_ready_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rm_stall got=%b exp=0", stall_o); end
    checks++; if (rd_wren_o !== 1'b0) begin failures++; $display("FAIL rm_wren_in_rst got=%b exp=0", rd_wren_o); end
    tick();
    rst_i = 0;
    pipe_set(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rd_wren_o !== 1'b0) begin failures++; $display("FAIL rm_wren cyc=%0d got=%b exp=0", i, rd_wren_o); end
      checks++; if (lu_ready_o !== 1'b1 || err_o !== 1'b0) begin failures++; $display("FAIL rm_state cyc=%0d got=%b/%b exp=1/0", i, lu_ready_o, err_o); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_pipe_err();
    do_reset();
    issue(5'd9);
    pipe_set(1, 5'd9, 32'hDEAD);
    #1;
    checks++; if (rd_wren_o !== 1'b1 || rd_addr_o !== 5'd9 || rd_data_o !== 32'hDEAD) begin failures++; $display("FAIL pe_write got=%b/%0d/%h exp=1/9/dead", rd_wren_o, rd_addr_o, rd_data_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL pe_err_early got=%b exp=0", err_o); end
    tick();
    pipe_set(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL pe_err_sticky cyc=%0d got=%b exp=1", i, err_o); end
      tick();
    end
    do_reset();
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL pe_err_rst got=%b exp=0", err_o); end
  endtask

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  task automatic test_random();
    ent_t q[$];
    bit   bm[32];
    int   sm;
    bit   em;
    int   pipe_pct;
    logic e_ready, e_stall, e_hold, e_vld, e_wren, fire, byp;
    logic [4:0]  ea;
    logic [31:0] ed;
    int   sz;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      q.delete();
      for (int k = 0; k < 32; k++) bm[k] = 0;
      sm = 0; em = 0;
      pipe_pct = 30 + 20 * seg;
      for (int cyc = 0; cyc < 120; cyc++) begin
        pipe_set(($urandom_range(0, 99) < pipe_pct), 5'($urandom_range(0, 15)), $urandom);
        lu_set(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
        issue_i = ($urandom_range(0, 3) == 0);
        issue_rd_addr_i = 5'($urandom_range(0, 7));
        dec_rs1_addr_i = 5'($urandom_range(0, 7));
        dec_rs2_addr_i = 5'($urandom_range(0, 7));
        dec_rd_addr_i  = 5'($urandom_range(0, 7));
        #1;
        sz = q.size();
        e_ready = (sz < DEPTH);
        e_stall = bm[dec_rs1_addr_i] | bm[dec_rs2_addr_i] | bm[dec_rd_addr_i];
        e_hold  = (sm == SMAX);
        e_vld = 0; ea = 0; ed = 0; byp = 0;
        if (pipe_wren_i) begin e_vld = 1; ea = pipe_rd_addr_i; ed = pipe_rd_data_i; end
        else if (sz > 0) begin e_vld = 1; ea = q[0].a; ed = q[0].d; end
        else if (lu_valid_i) begin e_vld = 1; ea = lu_rd_addr_i; ed = lu_rd_data_i; byp = 1; end
        e_wren = e_vld && (ea != 0);
        checks++; if (rd_wren_o !== e_wren) begin failures++; $display("FAIL rnd_wren seg=%0d cyc=%0d got=%b exp=%b", seg, cyc, rd_wren_o, e_wren); end
        if (e_wren) begin
          checks++; if (rd_addr_o !== ea || rd_data_o !== ed) begin failures++; $display("FAIL rnd_port seg=%0d cyc=%0d got=%0d/%h exp=%0d/%h", seg, cyc, rd_addr_o, rd_data_o, ea, ed); end
        end
        checks++; if (lu_ready_o !== e_ready) begin failures++; $display("FAIL rnd_ready seg=%0d cyc=%0d got=%b exp=%b", seg, cyc, lu_ready_o, e_ready); end
        checks++; if (stall_o !== e_stall) begin failures++; $display("FAIL rnd_stall seg=%0d cyc=%0d got=%b exp=%b", seg, cyc, stall_o, e_stall); end
        checks++; if (pipe_hold_o !== e_hold) begin failures++; $display("FAIL rnd_hold seg=%0d cyc=%0d got=%b exp=%b", seg, cyc, pipe_hold_o, e_hold); end
        checks++; if (err_o !== em) begin failures++; $display("FAIL rnd_err seg=%0d cyc=%0d got=%b exp=%b", seg, cyc, err_o, em); end
        // Reference model update for this clock edge
        fire = lu_valid_i && e_ready;
        if (pipe_wren_i && pipe_rd_addr_i != 0 && bm[pipe_rd_addr_i]) em = 1;
        if (issue_i && issue_rd_addr_i != 0 && bm[issue_rd_addr_i]) em = 1;
        if (fire && lu_rd_addr_i != 0 && !bm[lu_rd_addr_i]) em = 1;
        if (!pipe_wren_i && sz > 0) begin
          bm[q[0].a] = 0;
          void'(q.pop_front());
        end else if (byp) begin
          bm[lu_rd_addr_i] = 0;
        end
        if (fire && !byp) q.push_back('{a: lu_rd_addr_i, d: lu_rd_data_i});
        if (issue_i && issue_rd_addr_i != 0) bm[issue_rd_addr_i] = 1;
        if (pipe_wren_i && sz > 0) sm = (sm < SMAX) ? sm + 1 : SMAX;
        else sm = 0;
        tick();
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_i = 1;
    idle_inputs();
    test_reset();
    test_bypass();
    test_backpressure();
    test_starvation();
    test_x0();
    test_reset_mid();
    test_pipe_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
